// File: rtl/iter_multiplier.sv
// Sequential shift-and-add multiplier with optional 32/64-bit accumulate.
// Consumes STEP multiplier bits per cycle and stops once the remaining multiplier bits are zero.
module iter_multiplier #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    output logic             ack,
    output logic             busy,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] Rm,
    input  logic [WIDTH-1:0] Rs,
    input  logic [WIDTH-1:0] Rn,
    input  logic [WIDTH-1:0] Rd_hi,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             n_flag,
    output logic             z_flag
);

    localparam int AW     = 2 * WIDTH;
    localparam int CYCLES = WIDTH / STEP;
    localparam int CW     = $clog2(CYCLES + 1);

    if (STEP != 1 && STEP != 2 && STEP != 4) begin : g_bad_step
        $error("iter_multiplier: STEP must be 1, 2 or 4");
    end
    if ((WIDTH % STEP) != 0) begin : g_bad_width
        $error("iter_multiplier: WIDTH must be a multiple of STEP");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   rm_reg;
    logic [WIDTH-1:0] rs_reg;
    logic [1:0]      mode_reg;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   count;

    logic [STEP-1:0]  digit;
    logic [AW-1:0]    partial;
    logic [AW-1:0]    acc_sum;
    logic [WIDTH-1:0] rs_shift;
    logic             last;
    logic             n_next;
    logic             z_next;

    always_comb begin
        digit    = rs_reg[STEP-1:0];
        partial  = rm_reg * AW'(digit);
        acc_sum  = acc + partial;
        rs_shift = rs_reg >> STEP;
        last     = (rs_shift == '0) || (count == CW'(CYCLES - 1));
        // Long modes flag the full 2*WIDTH result; short modes only the low word.
        if (mode_reg[1]) begin
            n_next = acc_sum[AW-1];
            z_next = (acc_sum == '0);
        end else begin
            n_next = acc_sum[WIDTH-1];
            z_next = (acc_sum[WIDTH-1:0] == '0);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req)   state_next = CALC;
            CALC:    if (last)  state_next = DONE;
            DONE:    if (!req)  state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ack   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            ack   <= (state_next == DONE);
            busy  <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rm_reg    <= '0;
            rs_reg    <= '0;
            mode_reg  <= '0;
            acc       <= '0;
            count     <= '0;
            result    <= '0;
            result_hi <= '0;
            n_flag    <= 1'b0;
            z_flag    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        rm_reg   <= AW'(Rm);
                        rs_reg   <= Rs;
                        mode_reg <= mode;
                        count    <= '0;
                        case (mode)
                            2'b01:   acc <= {{WIDTH{1'b0}}, Rn};
                            2'b11:   acc <= {Rd_hi, Rn};
                            default: acc <= '0;
                        endcase
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    rm_reg <= rm_reg << STEP;
                    rs_reg <= rs_shift;
                    count  <= count + CW'(1);
                    if (last) begin
                        result    <= acc_sum[WIDTH-1:0];
                        result_hi <= acc_sum[AW-1:WIDTH];
                        n_flag    <= n_next;
                        z_flag    <= z_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_multiplier.sv
// Randomised scoreboard bench for iter_multiplier; three instances (STEP 1, 2, 4) share one
// req/operand stream and are each checked against a plain-arithmetic reference model.
module tb_iter_multiplier;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] res_hi;
        logic        n;
        logic        z;
        int          cap;
        int          hb;
        logic        pulse;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] Rm = '0;
    logic [31:0] Rs = '0;
    logic [31:0] Rn = '0;
    logic [31:0] Rd_hi = '0;

    logic [2:0]       ack_v;
    logic [2:0]       busy_v;
    logic [2:0][31:0] res_v;
    logic [2:0][31:0] resh_v;
    logic [2:0]       n_v;
    logic [2:0]       z_v;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   done_cnt[3] = '{0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iter_multiplier #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack_v[0]), .busy(busy_v[0]), .mode(mode),
        .Rm(Rm), .Rs(Rs), .Rn(Rn), .Rd_hi(Rd_hi), .result(res_v[0]), .result_hi(resh_v[0]),
        .n_flag(n_v[0]), .z_flag(z_v[0]));
    iter_multiplier #(.WIDTH(32), .STEP(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack_v[1]), .busy(busy_v[1]), .mode(mode),
        .Rm(Rm), .Rs(Rs), .Rn(Rn), .Rd_hi(Rd_hi), .result(res_v[1]), .result_hi(resh_v[1]),
        .n_flag(n_v[1]), .z_flag(z_v[1]));
    iter_multiplier #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack_v[2]), .busy(busy_v[2]), .mode(mode),
        .Rm(Rm), .Rs(Rs), .Rn(Rn), .Rd_hi(Rd_hi), .result(res_v[2]), .result_hi(resh_v[2]),
        .n_flag(n_v[2]), .z_flag(z_v[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: product of the whole operands plus the accumulator, in 64-bit arithmetic.
    function automatic exp_t model(input logic [1:0] m, input logic [31:0] rm, input logic [31:0] rs,
                                   input logic [31:0] rn, input logic [31:0] rdhi);
        exp_t        e;
        logic [63:0] base;
        logic [63:0] p;
        case (m)
            2'b01:   base = {32'd0, rn};
            2'b11:   base = {rdhi, rn};
            default: base = 64'd0;
        endcase
        p = base + {32'd0, rm} * {32'd0, rs};
        e.res    = p[31:0];
        e.res_hi = p[63:32];
        if (m[1]) begin
            e.n = p[63];
            e.z = (p == 64'd0);
        end else begin
            e.n = p[31];
            e.z = (p[31:0] == 32'd0);
        end
        e.hb = -1;
        for (int i = 0; i < 32; i++) if (rs[i]) e.hb = i;
        e.cap   = 0;
        e.pulse = 1'b0;
        return e;
    endfunction

    function automatic int latency(input int hb, input int step);
        if (hb < 0) return 1;
        return (hb + step) / step;
    endfunction

    function automatic bit all_done(input int t0, input int t1, input int t2);
        return (done_cnt[0] >= t0) && (done_cnt[1] >= t1) && (done_cnt[2] >= t2);
    endfunction

    // Monitor: each rising ack consumes one expected record for that instance.
    logic [2:0] prev_ack = '0;
    int         hi_len[3] = '{0, 0, 0};
    logic [2:0] pulse_k = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (ack_v[k] && !prev_ack[k]) begin
                    exp_t e;
                    bit   got;
                    got = 1'b0;
                    e   = '0;
                    case (k)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                    endcase
                    if (!got) begin
                        checks++;
                        errors++;
                        $display("FAIL d%0d_unexpected_ack: got ack=1 expected no completion", k);
                    end else begin
                        chk($sformatf("d%0d_result", k), 64'(res_v[k]), 64'(e.res));
                        chk($sformatf("d%0d_result_hi", k), 64'(resh_v[k]), 64'(e.res_hi));
                        chk($sformatf("d%0d_n_flag", k), 64'(n_v[k]), 64'(e.n));
                        chk($sformatf("d%0d_z_flag", k), 64'(z_v[k]), 64'(e.z));
                        chk($sformatf("d%0d_latency", k), 64'(cyc - e.cap), 64'(latency(e.hb, 1 << k)));
                        pulse_k[k] = e.pulse;
                        hi_len[k]  = 1;
                        done_cnt[k]++;
                    end
                end else if (ack_v[k]) begin
                    hi_len[k]++;
                end else if (prev_ack[k] && pulse_k[k]) begin
                    chk($sformatf("d%0d_ack_pulse_len", k), 64'(hi_len[k]), 64'd1);
                end
            end
            prev_ack = ack_v;
        end
    end

    task automatic push_exp(input exp_t e);
        q0.push_back(e);
        q1.push_back(e);
        q2.push_back(e);
    endtask

    task automatic wait_done(input int t0, input int t1, input int t2);
        int t;
        for (t = 0; t < 200 && !all_done(t0, t1, t2); t++) @(negedge clk);
        if (!all_done(t0, t1, t2)) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: got done=%0d/%0d/%0d expected %0d/%0d/%0d",
                     done_cnt[0], done_cnt[1], done_cnt[2], t0, t1, t2);
        end
    endtask

    task automatic do_op(input logic [1:0] m, input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] rn, input logic [31:0] rdhi, input bit early, input int hold);
        exp_t e;
        int   t0, t1, t2;
        @(negedge clk);
        mode = m; Rm = rm; Rs = rs; Rn = rn; Rd_hi = rdhi;
        req  = 1'b1;
        e       = model(m, rm, rs, rn, rdhi);
        e.cap   = cyc + 1;
        e.pulse = early;
        push_exp(e);
        t0 = done_cnt[0] + 1; t1 = done_cnt[1] + 1; t2 = done_cnt[2] + 1;
        @(negedge clk);
        // Operands and mode are scrambled after capture; they must have no effect.
        mode = 2'($urandom_range(0, 3));
        Rm = $urandom; Rs = $urandom; Rn = $urandom; Rd_hi = $urandom;
        if (early) req = 1'b0;
        wait_done(t0, t1, t2);
        if (!early) begin
            repeat (hold) @(negedge clk);
            chk("ack_held_in_done", 64'(ack_v), 64'h7);
            req = 1'b0;
            @(negedge clk);
        end else begin
            repeat (2) @(negedge clk);
        end
        chk("ack_after_release", 64'(ack_v), 64'h0);
        chk("busy_after_release", 64'(busy_v), 64'h0);
    endtask

    initial begin
        logic [31:0] r;
        exp_t        e;
        int          t0, t1, t2;

        #12;
        chk("reset_ack", 64'(ack_v), 64'h0);
        chk("reset_busy", 64'(busy_v), 64'h0);
        chk("reset_result", 64'(res_v), 64'h0);
        chk("reset_result_hi", 64'(resh_v), 64'h0);
        chk("reset_flags", 64'({n_v, z_v}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, then a chain feeding each result back as the multiplier.
        do_op(2'b00, 32'd2, 32'd2, 32'd0, 32'd0, 1'b0, 1);
        r = 32'd4;
        for (int i = 0; i < 4; i++) begin
            do_op(2'b00, 32'd2, r, 32'd0, 32'd0, 1'b0, 0);
            e = model(2'b00, 32'd2, r, 32'd0, 32'd0);
            r = e.res;
        end
        do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 0);
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 0);
        do_op(2'b01, 32'd3, 32'd5, 32'd7, 32'd0, 1'b0, 0);
        do_op(2'b01, 32'd9, 32'd0, 32'h12345678, 32'd0, 1'b0, 0);
        do_op(2'b00, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, 0);
        do_op(2'b11, 32'd1, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 0);
        do_op(2'b10, 32'hABCD, 32'h10, 32'd0, 32'd0, 1'b0, 0);
        do_op(2'b01, 32'h1234, 32'h00FF00FF, 32'd5, 32'd0, 1'b1, 0);
        do_op(2'b00, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 0);

        // Reset in the middle of a long operation, with req still high afterwards.
        @(negedge clk);
        mode = 2'b10; Rm = 32'h89ABCDEF; Rs = 32'hFFFFFFFF; Rn = 32'd0; Rd_hi = 32'd0;
        req  = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_ack", 64'(ack_v), 64'h0);
        chk("midreset_busy", 64'(busy_v), 64'h0);
        chk("midreset_result", 64'(res_v), 64'h0);
        chk("midreset_result_hi", 64'(resh_v), 64'h0);
        chk("midreset_flags", 64'({n_v, z_v}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        e     = model(2'b10, 32'h89ABCDEF, 32'hFFFFFFFF, 32'd0, 32'd0);
        e.cap = cyc + 1;
        push_exp(e);
        t0 = done_cnt[0] + 1; t1 = done_cnt[1] + 1; t2 = done_cnt[2] + 1;
        wait_done(t0, t1, t2);
        req = 1'b0;
        @(negedge clk);
        chk("postreset_ack_release", 64'(ack_v), 64'h0);

        for (int i = 0; i < 30; i++) begin
            do_op(2'($urandom_range(0, 3)), $urandom, $urandom >> $urandom_range(0, 31),
                  $urandom, $urandom, ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
